// File: rtl/register_file_pkg.sv
// Shared definitions for the register file: clear-sequencer state encoding and address sizing.
package register_file_pkg;

    typedef enum logic [1:0] {
        CLR_IDLE  = 2'd0,
        CLR_SWEEP = 2'd1,
        CLR_DONE  = 2'd2
    } clr_state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/register_file_clear_seq.sv
// Clear sequencer: walks ptr over every entry, one per cycle, then pulses clr_done.
// Latency: DEPTH busy cycles after the accepting edge, then one DONE cycle.
// Backpressure: clr_req is only sampled in IDLE; requests in SWEEP/DONE are dropped.
module register_file_clear_seq
    import register_file_pkg::*;
#(
    parameter int  DEPTH = 8,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          clr_req,
    output logic          busy,
    output logic          clr_done,
    output logic [AW-1:0] ptr
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    clr_state_t    state, state_nxt;
    logic [AW-1:0] ptr_nxt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= CLR_IDLE;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        case (state)
            CLR_IDLE: begin
                if (clr_req) begin
                    state_nxt = CLR_SWEEP;
                    ptr_nxt   = '0;
                end
            end
            CLR_SWEEP: begin
                // Stop at the last real entry so odd DEPTH never walks off the end.
                if (ptr == LAST) begin
                    state_nxt = CLR_DONE;
                    ptr_nxt   = '0;
                end else begin
                    ptr_nxt = ptr + AW'(1);
                end
            end
            CLR_DONE: state_nxt = CLR_IDLE;
            default:  state_nxt = CLR_IDLE;
        endcase
    end

    assign busy     = (state == CLR_SWEEP);
    assign clr_done = (state == CLR_DONE);

endmodule

// File: rtl/register_file.sv
// Multi-entry register bank: one write port, two combinational read ports, optional bypass, sequenced clear.
// Latency: writes land at the posedge; reads are combinational (same cycle with BYPASS=1).
// Backpressure: writes during a clear sweep or to out-of-range addresses are dropped and flagged on wr_drop.
module register_file
    import register_file_pkg::*;
#(
    parameter int  WIDTH  = 16,
    parameter int  DEPTH  = 8,
    parameter int  BYPASS = 0,
    localparam int AW     = clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic [AW-1:0]    waddr,
    input  logic [AW-1:0]    raddr_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    input  logic             clr_req,
    output logic             busy,
    output logic             clr_done,
    output logic             wr_drop
);

    // One extra bit keeps the range test meaningful when DEPTH is a power of 2.
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    clr_ptr;
    logic             accept;

    register_file_clear_seq #(.DEPTH(DEPTH)) u_clear_seq (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_done (clr_done),
        .ptr      (clr_ptr)
    );

    assign accept = load && !busy && ({1'b0, waddr} < DEPTH_W);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_drop <= 1'b0;
        end else begin
            wr_drop <= load && !accept;
            if (busy)
                mem[clr_ptr] <= '0;
            else if (accept)
                mem[waddr] <= in;
        end
    end

    always_comb begin
        out_a = '0;
        out_b = '0;
        if ({1'b0, raddr_a} < DEPTH_W) out_a = mem[raddr_a];
        if ({1'b0, raddr_b} < DEPTH_W) out_b = mem[raddr_b];
        if (BYPASS != 0 && accept && waddr == raddr_a) out_a = in;
        if (BYPASS != 0 && accept && waddr == raddr_b) out_b = in;
    end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: DEPTH=8 no-bypass, DEPTH=8 bypass and DEPTH=6 instances share stimulus.
module tb_register_file;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] din;
    logic        load;
    logic [2:0]  waddr, raddr_a, raddr_b;
    logic        clr_req;

    logic [15:0] a8, b8, ab, bb, a6, b6;
    logic        busy8, done8, drop8;
    logic        busyb, doneb, dropb;
    logic        busy6, done6, drop6;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    register_file #(.WIDTH(16), .DEPTH(8), .BYPASS(0)) u_rf8 (
        .CLK(clk), .RST_N(rst_n), .in(din), .load(load), .waddr(waddr),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .out_a(a8), .out_b(b8),
        .clr_req(clr_req), .busy(busy8), .clr_done(done8), .wr_drop(drop8)
    );

    register_file #(.WIDTH(16), .DEPTH(8), .BYPASS(1)) u_rfb (
        .CLK(clk), .RST_N(rst_n), .in(din), .load(load), .waddr(waddr),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .out_a(ab), .out_b(bb),
        .clr_req(clr_req), .busy(busyb), .clr_done(doneb), .wr_drop(dropb)
    );

    register_file #(.WIDTH(16), .DEPTH(6), .BYPASS(0)) u_rf6 (
        .CLK(clk), .RST_N(rst_n), .in(din), .load(load), .waddr(waddr),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .out_a(a6), .out_b(b6),
        .clr_req(clr_req), .busy(busy6), .clr_done(done6), .wr_drop(drop6)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        int seen;
        rst_n = 1'b0; din = '0; load = 1'b0; waddr = '0;
        raddr_a = '0; raddr_b = '0; clr_req = 1'b0;
        step(); step(); settle();
        chk("rst out_a", a8, 0);
        chk("rst busy", busy8, 0);
        chk("rst clr_done", done8, 0);
        chk("rst wr_drop", drop8, 0);
        rst_n = 1'b1;
        step();

        // basic writes; addr 7 is out of range for the DEPTH=6 instance
        load = 1'b1; waddr = 3'd3; din = 16'h1234; step();
        waddr = 3'd7; din = 16'hBEEF; step();
        load = 1'b0; settle();
        chk("d6 drop waddr7", drop6, 1);
        chk("d8 no drop waddr7", drop8, 0);
        raddr_a = 3'd3; raddr_b = 3'd7; settle();
        chk("rd a addr3", a8, 16'h1234);
        chk("rd b addr7", b8, 16'hBEEF);
        chk("d6 rd b addr7", b6, 0);
        for (int i = 0; i < 8; i++) begin
            if (i != 3 && i != 7) begin
                raddr_a = 3'(i); settle();
                chk("untouched zero", a8, 0);
            end
        end

        // bypass vs registered visibility
        raddr_a = 3'd2; raddr_b = 3'd2; waddr = 3'd2; din = 16'hAAAA; load = 1'b1; settle();
        chk("nobyp same cycle", a8, 0);
        chk("byp a same cycle", ab, 16'hAAAA);
        chk("byp b same cycle", bb, 16'hAAAA);
        step(); load = 1'b0; settle();
        chk("nobyp after edge", a8, 16'hAAAA);

        // fill every address with 0x0101*(i+1)
        for (int i = 0; i < 8; i++) begin
            load = 1'b1; waddr = 3'(i); din = 16'(257 * (i + 1));
            step(); settle();
            chk("d6 fill drop", drop6, (i >= 6) ? 1 : 0);
        end
        load = 1'b0;
        for (int i = 0; i < 6; i++) begin
            raddr_a = 3'(i); settle();
            chk("d6 fill rd", a6, 257 * (i + 1));
        end
        raddr_a = 3'd7; settle();
        chk("d6 rd addr7", a6, 0);
        chk("d8 rd addr7", a8, 16'h0808);

        // sweep: clr_req seen at edge k
        clr_req = 1'b1; step(); clr_req = 1'b0;
        for (int j = 0; j < 8; j++) begin
            raddr_a = 3'(j);
            if (j > 0) raddr_b = 3'(j - 1);
            settle();
            chk("sweep busy", busy8, 1);
            chk("sweep entry pending", a8, 257 * (j + 1));
            if (j > 0) chk("sweep entry cleared", b8, 0);
            chk("d6 busy", busy6, (j < 6) ? 1 : 0);
            chk("d6 clr_done", done6, (j == 6) ? 1 : 0);
            if (j == 0) chk("byp sweep busy", busyb, 1);
            if (j == 3) begin
                chk("sweep wr_drop", drop8, 1);
                chk("byp sweep wr_drop", dropb, 1);
            end
            load = (j == 2); waddr = 3'd5; din = 16'h5555;
            step();
        end
        load = 1'b0; settle();
        chk("done busy", busy8, 0);
        chk("done pulse", done8, 1);
        chk("byp done pulse", doneb, 1);
        load = 1'b1; waddr = 3'd1; din = 16'h7777;
        step(); load = 1'b0; settle();
        chk("done ends", done8, 0);
        raddr_a = 3'd1; raddr_b = 3'd5; settle();
        chk("write in DONE", a8, 16'h7777);
        chk("dropped stays 0", b8, 0);
        for (int i = 0; i < 8; i++) begin
            if (i != 1) begin
                raddr_a = 3'(i); settle();
                chk("post sweep zero", a8, 0);
            end
        end

        // reset in sweep cycle 3 aborts without a pulse
        for (int i = 4; i < 8; i++) begin
            load = 1'b1; waddr = 3'(i); din = 16'(16'h1111 * i); step();
        end
        load = 1'b0;
        clr_req = 1'b1; step(); clr_req = 1'b0;
        step(); step(); step();
        raddr_a = 3'd5; settle();
        chk("pre-abort entry5", a8, 16'h5555);
        rst_n = 1'b0; settle();
        chk("abort busy", busy8, 0);
        for (int i = 4; i < 8; i++) begin
            raddr_a = 3'(i); settle();
            chk("abort zero", a8, 0);
        end
        seen = 0;
        step();
        if (done8 || busy8) seen = 1;
        rst_n = 1'b1;
        repeat (12) begin
            step();
            if (done8 || busy8) seen = 1;
        end
        chk("no pulse after abort", seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
